// File: rtl/alu_mp_seq.sv
// alu_mp_seq: multi-precision sequencer wrapped around an 8-bit combinational alu.
// Accepts one wide operation and breaks it into byte-wide alu passes. It chains
// carry/borrow and cross-byte shift bits, then assembles the wide result and the
// final carry.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_a, in_b, in_op are the request
//   out_valid/out_ready   response handshake; out_result, out_carry are the response
//   alu_a/alu_b/alu_op    drive the external alu (registered)
//   alu_result/alu_carry  alu outputs, sampled in the same cycle they are driven
module alu_mp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_result,
    output logic                  out_carry,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_op,
    input  logic [7:0]            alu_result,
    input  logic                  alu_carry
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] ILAST = IW'(NBYTES - 1);

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SHL = 3'b110, OP_SHR = 3'b111;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_q, b_q;
    logic [2:0]     op_q;
    logic [IW-1:0]  idx;
    logic           cf;      // chain flag: carry, borrow or shifted-in bit
    logic           c1;      // PASS1 carry / no-borrow of the current byte
    logic [7:0]     byte_v;
    logic           cf_nxt;
    logic           last;
    logic [IW-1:0]  idx_nxt;
    logic           arith;

    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Byte produced this cycle and the chain flag it leaves behind.
    always_comb begin
        byte_v = alu_result;
        cf_nxt = cf;
        if (state == PASS2) begin
            cf_nxt = (op_q == OP_ADD) ? (c1 | alu_carry) : ~(c1 & alu_carry);
        end else if (op_q == OP_SHL) begin
            byte_v = alu_result | {7'b0, cf};
            cf_nxt = a_q[int'(idx)*8 + 7];
        end else if (op_q == OP_SHR) begin
            byte_v = alu_result | {cf, 7'b0};
            cf_nxt = a_q[int'(idx)*8];
        end
    end

    // SHR walks bytes from the top down so the shifted-in bit comes from above.
    assign last    = (op_q == OP_SHR) ? (idx == '0) : (idx == ILAST);
    assign idx_nxt = (op_q == OP_SHR) ? idx - 1'b1 : idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            idx        <= '0;
            cf         <= 1'b0;
            c1         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        op_q     <= in_op;
                        cf       <= 1'b0;
                        in_ready <= 1'b0;
                        alu_op   <= in_op;
                        if (in_op == OP_SHR) begin
                            idx   <= ILAST;
                            alu_a <= in_a[W-1 -: 8];
                        end else begin
                            idx   <= '0;
                            alu_a <= in_a[7:0];
                        end
                        // b only matters for the two-operand ops
                        alu_b <= (in_op < 3'b101) ? in_b[7:0] : 8'h00;
                        state <= PASS1;
                    end
                end
                PASS1, PASS2: begin
                    if (state == PASS1 && arith) begin
                        // Second pass folds the incoming carry/borrow into this byte.
                        c1    <= alu_carry;
                        alu_a <= alu_result;
                        alu_b <= {7'b0, cf};
                        state <= PASS2;
                    end else begin
                        out_result[int'(idx)*8 +: 8] <= byte_v;
                        cf <= cf_nxt;
                        if (last) begin
                            out_valid <= 1'b1;
                            out_carry <= (op_q == OP_SUB) ? ~cf_nxt :
                                         (arith || op_q == OP_SHL || op_q == OP_SHR) ? cf_nxt : 1'b0;
                            alu_a     <= '0;
                            alu_b     <= '0;
                            alu_op    <= '0;
                            state     <= DONE;
                        end else begin
                            idx    <= idx_nxt;
                            alu_a  <= a_q[int'(idx_nxt)*8 +: 8];
                            alu_b  <= (op_q < 3'b101) ? b_q[int'(idx_nxt)*8 +: 8] : 8'h00;
                            alu_op <= op_q;
                            state  <= PASS1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mp_seq.sv
// tb_alu_mp_seq: bench for alu_mp_seq with NBYTES=4. It provides a behavioural 8-bit
// alu and a wide reference model. Expected results are queued on accept and then
// compared when out_valid appears.
module tb_alu_mp_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [2:0]    in_op;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry;
    logic [7:0]    alu_a, alu_b, alu_result;
    logic [2:0]    alu_op;
    logic          alu_carry;

    always #5 clk = ~clk;

    alu_mp_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    // Behavioural 8-bit alu (no carry-in)
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        case (alu_op)
            3'b000: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: begin alu_result = alu_a - alu_b; alu_carry = (alu_a >= alu_b); end
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~alu_a;
            3'b110: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
            default: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   npass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else npass++;
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e.c = 1'b0;
        e.lat = (op <= 3'b001) ? 2 * NB : NB;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.c = s[W]; end
            3'b001: begin e.res = a - b; e.c = (a >= b); end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = a ^ b;
            3'b101: e.res = ~a;
            3'b110: begin e.res = {a[W-2:0], 1'b0}; e.c = a[W-1]; end
            default: begin e.res = {1'b0, a[W-1:1]}; e.c = a[0]; end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall);
        int n;
        exp_t e;
        logic [W-1:0] held;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_op = op; in_a = a; in_b = b; out_ready = 0;
        @(posedge clk);
        sb.push_back(model(op, a, b));
        #1 in_valid = 0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("latency", 64'(n), 64'(e.lat));
        chk("result", out_result, e.res);
        chk("carry", out_carry, e.c);
        chk("done_alu", {alu_a, alu_b, alu_op}, 0);
        held = out_result;
        for (int k = 0; k < stall; k++) begin
            // A request offered while busy must be ignored.
            in_valid = 1; in_op = 3'b000; in_a = 32'h12345678; in_b = 32'h1;
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, held);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_result_kept", out_result, held);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; out_ready = 0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_carry", out_carry, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        @(negedge clk); rst = 0;

        run_op(3'b000, 32'h000000FF, 32'h00000001, 0);
        run_op(3'b000, 32'hFFFFFFFF, 32'h00000001, 0);
        run_op(3'b000, 32'h80000000, 32'h80000000, 0);
        run_op(3'b001, 32'h00000100, 32'h00000001, 0);
        run_op(3'b001, 32'h00000000, 32'h00000001, 0);
        run_op(3'b110, 32'h80808080, 32'h0, 0);
        run_op(3'b111, 32'h01010101, 32'h0, 0);
        run_op(3'b100, 32'h0F0F0F0F, 32'hFFFF0000, 0);
        run_op(3'b010, 32'hF0F0A5A5, 32'hFF00FF00, 0);
        run_op(3'b011, 32'h00F0A500, 32'h0F000F00, 0);
        run_op(3'b101, 32'h12345678, 32'h0, 0);
        run_op(3'b000, 32'h00000003, 32'h00000004, 5);

        for (int r = 0; r < 16; r++)
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, r % 2);

        // Reset during PASS2 of byte 2: five edges after the accept edge.
        @(negedge clk);
        in_valid = 1; in_op = 3'b000; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        @(posedge clk); #1 in_valid = 0;
        repeat (5) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_alu", {alu_a, alu_b, alu_op}, 0);
        @(negedge clk); rst = 0;
        run_op(3'b000, 32'h00000001, 32'h00000001, 0);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
